// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Brief    : Shared screen geometry, coordinate width and animation states.
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_anim_ctrl
//  Brief    : Animation sequencer: hold counter, frame index and done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 8,
    parameter int HOLD_TICKS = 4,
    parameter int LOOP       = 0,
    parameter int c_FRAME_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_frame_tick,
    input  logic                 i_anim_start,
    output logic [c_FRAME_W-1:0] o_frame_idx,
    output logic                 o_anim_busy,
    output logic                 o_anim_done
);

    localparam int c_HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(NUM_FRAMES - 1);

    anim_state_t          r_state;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_FRAME_W-1:0] r_frame;
    logic                 r_busy;
    logic                 r_done;

    // A start pulse always wins; a tick arriving with it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_frame <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_anim_start) begin
                r_state <= PLAY;
                r_hold  <= '0;
                r_frame <= '0;
                r_busy  <= 1'b1;
            end else if ((r_state == PLAY) && i_frame_tick) begin
                if (r_hold == c_HOLD_LAST) begin
                    r_hold <= '0;
                    if (r_frame == c_FRAME_LAST) begin
                        r_done <= 1'b1;
                        if (LOOP != 0) begin
                            r_frame <= '0;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_frame <= r_frame + c_FRAME_W'(1);
                    end
                end else begin
                    r_hold <= r_hold + c_HOLD_W'(1);
                end
            end
        end
    end

    assign o_frame_idx = r_frame;
    assign o_anim_busy = r_busy;
    assign o_anim_done = r_done;

endmodule
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_addr_gen
//  Brief    : Maps VGA beam position to sprite ROM address with animation
//             frames; horizontal mirroring enabled by SPRITE_MIRROR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 64,
    parameter int SPRITE_H   = 128,
    parameter int NUM_FRAMES = 8,
    parameter int HOLD_TICKS = 4,
    parameter int LOOP       = 0,
    parameter int ADDR_W     = 16,
    parameter int c_FRAME_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   draw_x,
    input  logic [COORD_W-1:0]   draw_y,
    input  logic                 blank_in,
    input  logic                 frame_tick,
    input  logic [COORD_W-1:0]   pos_x,
    input  logic [COORD_W-1:0]   pos_y,
    input  logic                 facing_left,
    input  logic                 anim_start,
    output logic [ADDR_W-1:0]    rom_address,
    output logic                 in_sprite,
    output logic                 blank_out,
    output logic [c_FRAME_W-1:0] frame_idx,
    output logic                 anim_busy,
    output logic                 anim_done
);

    localparam int c_DELTA_W = COORD_W + 1;
    localparam int c_COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_ROW_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    logic [COORD_W-1:0]   r_pos_x;
    logic [COORD_W-1:0]   r_pos_y;
    logic [c_DELTA_W-1:0] w_dx;
    logic [c_DELTA_W-1:0] w_dy;
    logic                 w_hit;
    logic [c_COL_W-1:0]   w_col;
    logic [c_ROW_W-1:0]   w_row;
    logic [ADDR_W-1:0]    w_addr;
    logic [ADDR_W-1:0]    r_rom_address;
    logic                 r_in_sprite;
    logic                 r_blank;

    sprite_anim_ctrl #(
        .NUM_FRAMES (NUM_FRAMES),
        .HOLD_TICKS (HOLD_TICKS),
        .LOOP       (LOOP)
    ) u_anim_ctrl (
        .clk          (vga_clk),
        .rst          (reset),
        .i_frame_tick (frame_tick),
        .i_anim_start (anim_start),
        .o_frame_idx  (frame_idx),
        .o_anim_busy  (anim_busy),
        .o_anim_done  (anim_done)
    );

    // Placement is only taken at the frame boundary so a sprite never tears.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
        end else if (frame_tick) begin
            r_pos_x <= pos_x;
            r_pos_y <= pos_y;
        end
    end

    // Negative deltas wrap to large unsigned values and fail the bound test.
    assign w_dx  = {1'b0, draw_x} - {1'b0, r_pos_x};
    assign w_dy  = {1'b0, draw_y} - {1'b0, r_pos_y};
    assign w_hit = blank_in
                   && (w_dx < c_DELTA_W'(SPRITE_W))
                   && (w_dy < c_DELTA_W'(SPRITE_H));
    assign w_row = w_dy[c_ROW_W-1:0];

`ifdef SPRITE_MIRROR_EN
    logic r_facing;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_facing <= 1'b0;
        end else if (frame_tick) begin
            r_facing <= facing_left;
        end
    end

    assign w_col = r_facing ? (c_COL_W'(SPRITE_W - 1) - w_dx[c_COL_W-1:0])
                            : w_dx[c_COL_W-1:0];
`else
    logic w_unused_facing;

    assign w_unused_facing = facing_left;
    assign w_col           = w_dx[c_COL_W-1:0];
`endif

    assign w_addr = ADDR_W'(frame_idx) * ADDR_W'(SPRITE_W * SPRITE_H)
                  + ADDR_W'(w_row) * ADDR_W'(SPRITE_W)
                  + ADDR_W'(w_col);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_rom_address <= '0;
            r_in_sprite   <= 1'b0;
            r_blank       <= 1'b0;
        end else begin
            r_rom_address <= w_hit ? w_addr : '0;
            r_in_sprite   <= w_hit;
            r_blank       <= blank_in;
        end
    end

    assign rom_address = r_rom_address;
    assign in_sprite   = r_in_sprite;
    assign blank_out   = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_addr_gen
//  Brief    : Directed and random checks of sprite_addr_gen against a
//             frame-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_addr_gen;

    localparam int SPRITE_W   = 64;
    localparam int SPRITE_H   = 128;
    localparam int NUM_FRAMES = 8;
    localparam int HOLD_TICKS = 4;
    localparam int LOOP       = 0;
    localparam int ADDR_W     = 16;
    localparam int TOTAL      = NUM_FRAMES * HOLD_TICKS;
`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic              vga_clk = 1'b0;
    logic              reset;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic              blank_in;
    logic              frame_tick;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              facing_left;
    logic              anim_start;
    logic [ADDR_W-1:0] rom_address;
    logic              in_sprite;
    logic              blank_out;
    logic [2:0]        frame_idx;
    logic              anim_busy;
    logic              anim_done;

    sprite_addr_gen #(
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .NUM_FRAMES (NUM_FRAMES),
        .HOLD_TICKS (HOLD_TICKS),
        .LOOP       (LOOP),
        .ADDR_W     (ADDR_W)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .blank_in    (blank_in),
        .frame_tick  (frame_tick),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .facing_left (facing_left),
        .anim_start  (anim_start),
        .rom_address (rom_address),
        .in_sprite   (in_sprite),
        .blank_out   (blank_out),
        .frame_idx   (frame_idx),
        .anim_busy   (anim_busy),
        .anim_done   (anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;

    // Reference state: latched placement plus ticks counted since the last start.
    int m_px, m_py;
    bit m_face, m_started;
    int m_ticks;
    int e_addr, e_in, e_blank, e_done;
    int done_cnt;

    function automatic int model_frame();
        if (!m_started) return 0;
        if (LOOP != 0) return (m_ticks / HOLD_TICKS) % NUM_FRAMES;
        return (m_ticks / HOLD_TICKS >= NUM_FRAMES) ? NUM_FRAMES - 1 : m_ticks / HOLD_TICKS;
    endfunction

    function automatic bit model_busy();
        return m_started && ((LOOP != 0) || (m_ticks < TOTAL));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int dx, dy, col, fr;
        bit hit;
        fr  = model_frame();
        dx  = int'(draw_x) - m_px;
        dy  = int'(draw_y) - m_py;
        hit = blank_in && dx >= 0 && dx < SPRITE_W && dy >= 0 && dy < SPRITE_H;
        col = (MIRROR && m_face) ? SPRITE_W - 1 - dx : dx;
        e_done = 0;
        if (reset) begin
            m_px = 0; m_py = 0; m_face = 0; m_started = 0; m_ticks = 0;
            e_addr = 0; e_in = 0; e_blank = 0;
        end else begin
            e_in    = hit ? 1 : 0;
            e_addr  = hit ? fr * SPRITE_W * SPRITE_H + dy * SPRITE_W + col : 0;
            e_blank = blank_in ? 1 : 0;
            if (anim_start) begin
                m_started = 1; m_ticks = 0;
            end else if (frame_tick && model_busy()) begin
                m_ticks++;
                if (m_ticks % TOTAL == 0) e_done = 1;
            end
            if (frame_tick) begin
                m_px = int'(pos_x); m_py = int'(pos_y); m_face = facing_left;
            end
        end
        @(posedge vga_clk);
        #1;
        chk("rom_address", 32'(rom_address), 32'(e_addr));
        chk("in_sprite",   32'(in_sprite),   32'(e_in));
        chk("blank_out",   32'(blank_out),   32'(e_blank));
        chk("frame_idx",   32'(frame_idx),   32'(model_frame()));
        chk("anim_busy",   32'(anim_busy),   32'(model_busy()));
        chk("anim_done",   32'(anim_done),   32'(e_done));
        done_cnt += int'(anim_done);
    endtask

    task automatic beam(input int x, input int y);
        draw_x = 10'(x); draw_y = 10'(y); blank_in = 1'b1;
        cycle();
    endtask

    task automatic tick();
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b0; cycle();
    endtask

    initial begin
        reset = 1'b1; draw_x = '0; draw_y = '0; blank_in = 1'b0; frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; facing_left = 1'b0; anim_start = 1'b0; done_cnt = 0;
        cycle(); cycle();
        chk("reset_rom", 32'(rom_address), 0);
        chk("reset_frame", 32'(frame_idx), 0);
        reset = 1'b0;

        pos_x = 10'd100; pos_y = 10'd50;
        tick();
        beam(100, 50);
        chk("origin_addr", 32'(rom_address), 0);
        chk("origin_hit", 32'(in_sprite), 1);
        beam(163, 177);
        chk("corner_addr", 32'(rom_address), 8191);
        beam(164, 50);
        chk("right_edge_hit", 32'(in_sprite), 0);
        chk("right_edge_addr", 32'(rom_address), 0);
        beam(99, 50);
        beam(100, 178);

        pos_x = 10'd300;
        beam(163, 177);
        chk("no_tear_addr", 32'(rom_address), 8191);
        tick();
        beam(100, 50);
        chk("moved_hit", 32'(in_sprite), 0);
        pos_x = 10'd100;

        facing_left = 1'b1;
        tick();
        beam(100, 50);
        chk("mirror_addr", 32'(rom_address), MIRROR ? 63 : 0);
        facing_left = 1'b0;
        tick();

        anim_start = 1'b1; cycle(); anim_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("anim_frame1", 32'(frame_idx), 1);
        beam(100, 50);
        chk("frame1_addr", 32'(rom_address), 8192);
        anim_start = 1'b1; frame_tick = 1'b1; cycle();
        anim_start = 1'b0; frame_tick = 1'b0; cycle();

        anim_start = 1'b1; cycle(); anim_start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            frame_tick  = ($urandom_range(0, 7) == 0);
            anim_start  = ($urandom_range(0, 149) == 0);
            facing_left = 1'($urandom_range(0, 1));
            blank_in    = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 3) == 0) begin
                pos_x = 10'($urandom_range(0, 639));
                pos_y = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 4) == 0) begin
                draw_x = 10'($urandom_range(0, 799));
                draw_y = 10'($urandom_range(0, 524));
            end else begin
                draw_x = 10'(m_px + int'($urandom_range(0, SPRITE_W + 3)) - 2);
                draw_y = 10'(m_py + int'($urandom_range(0, SPRITE_H + 3)) - 2);
            end
            cycle();
        end
        frame_tick = 1'b0; anim_start = 1'b0;

        reset = 1'b1; cycle(); reset = 1'b0;
        pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
        anim_start = 1'b1; cycle(); anim_start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < TOTAL + 4; i++) tick();
        chk("done_pulses", 32'(done_cnt), 1);
        chk("end_frame", 32'(frame_idx), (LOOP != 0) ? 1 : NUM_FRAMES - 1);
        chk("end_busy", 32'(anim_busy), (LOOP != 0) ? 1 : 0);

        anim_start = 1'b1; cycle(); anim_start = 1'b0;
        for (int i = 0; i < 5 * HOLD_TICKS; i++) tick();
        chk("frame5", 32'(frame_idx), 5);
        beam(100, 50);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rst_frame", 32'(frame_idx), 0);
        chk("rst_busy", 32'(anim_busy), 0);
        chk("rst_rom", 32'(rom_address), 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
